ahb_master_mux_n: RTL and testbench

N-input AHB-Lite master multiplexer that merges several bus masters (e.g. CM3 I-code, D-code and system ports, or a DMA) onto one master port for the system interconnect. It is the parametrised successor of the fixed three-port mux. It adds selectable fixed-priority or round-robin arbitration, burst and lock retention, per-port address-phase holding registers, and an HMASTER output identifying the address-phase owner.

---
 rtl/ahb_master_mux_n.sv | 145 ++++++++++++++
 tb/tb_ahb_master_mux_n.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_mux_n.sv
// ahb_master_mux_n: N-port AHB-Lite master mux with fixed-priority/round-robin arbitration,
// burst/lock retention, per-port address holding registers and data-phase tracking.
module ahb_master_mux_n #(
    parameter int NUM_PORTS = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int ARB_MODE  = 0,
    parameter int MW        = 3
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [NUM_PORTS-1:0]    HSELS,
    input  logic [NUM_PORTS*AW-1:0] HADDRS,
    input  logic [NUM_PORTS*2-1:0]  HTRANSS,
    input  logic [NUM_PORTS*3-1:0]  HSIZES,
    input  logic [NUM_PORTS-1:0]    HWRITES,
    input  logic [NUM_PORTS*4-1:0]  HPROTS,
    input  logic [NUM_PORTS*3-1:0]  HBURSTS,
    input  logic [NUM_PORTS-1:0]    HMASTLOCKS,
    input  logic [NUM_PORTS*DW-1:0] HWDATAS,
    input  logic [NUM_PORTS-1:0]    HREADYS,
    output logic [NUM_PORTS-1:0]    HREADYOUTS,
    output logic [NUM_PORTS*2-1:0]  HRESPS,
    output logic [NUM_PORTS*DW-1:0] HRDATAS,
    output logic                    HSELM,
    output logic [AW-1:0]           HADDRM,
    output logic [1:0]              HTRANSM,
    output logic [2:0]              HSIZEM,
    output logic                    HWRITEM,
    output logic [3:0]              HPROTM,
    output logic [2:0]              HBURSTM,
    output logic                    HMASTLOCKM,
    output logic [DW-1:0]           HWDATAM,
    output logic                    HREADYM,
    output logic [MW-1:0]           HMASTERM,
    input  logic                    HREADYOUTM,
    input  logic [1:0]              HRESPM,
    input  logic [DW-1:0]           HRDATAM
);
    localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic [2:0]    size;
        logic          write;
        logic [3:0]    prot;
        logic [2:0]    burst;
        logic          lock;
    } ctrl_t;

    ctrl_t live_c [NUM_PORTS];
    ctrl_t hold_c [NUM_PORTS];
    ctrl_t src_c  [NUM_PORTS];
    ctrl_t m, o, last_c;
    logic [NUM_PORTS-1:0] hvalid, live, req, src_sel;
    logic [IW-1:0] owner, grant, winner, ptr, dp_owner;
    logic dp_valid, retain, arb_pt, any_req, active, msel, issue;

    always_comb begin
        live = '0;
        src_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            live_c[i] = {HADDRS[i*AW +: AW], HTRANSS[2*i +: 2], HSIZES[3*i +: 3], HWRITES[i],
                         HPROTS[4*i +: 4], HBURSTS[3*i +: 3], HMASTLOCKS[i]};
            src_c[i] = hvalid[i] ? hold_c[i] : live_c[i];
            src_sel[i] = hvalid[i] | HSELS[i];
            live[i] = HRESETn & HSELS[i] & HTRANSS[2*i+1] & HREADYS[i];
        end
    end

    assign req     = hvalid | live;
    assign any_req = |req;

    // descending scan so the first requester from the search start wins
    always_comb begin
        int idx;
        idx = 0;
        winner = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (ARB_MODE != 0) ? (int'(ptr) + k) % NUM_PORTS : k;
            if (req[idx]) winner = IW'(idx);
        end
    end

    // SEQ and BUSY both have trans[0] set: owner is mid-burst
    assign retain = HRESETn & ((src_sel[owner] & src_c[owner].trans[0]) | src_c[owner].lock);
    assign arb_pt = HREADYOUTM & ~retain;
    assign grant  = (arb_pt & any_req) ? winner : owner;
    assign active = HRESETn & (~arb_pt | any_req);
    assign msel   = active & src_sel[grant];
    assign m      = src_c[grant];
    assign o      = msel ? m : last_c;
    assign issue  = HREADYOUTM & msel & m.trans[1];

    assign HSELM      = msel;
    assign HTRANSM    = msel ? o.trans : 2'b00;
    assign HMASTLOCKM = msel & o.lock;
    assign HADDRM     = o.addr;
    assign HSIZEM     = o.size;
    assign HWRITEM    = o.write;
    assign HPROTM     = o.prot;
    assign HBURSTM    = o.burst;
    assign HMASTERM   = MW'(grant);
    assign HREADYM    = HREADYOUTM;
    assign HRDATAS    = {NUM_PORTS{HRDATAM}};

    always_comb begin
        HREADYOUTS = '1;
        HRESPS = '0;
        HWDATAM = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            HREADYOUTS[i] = hvalid[i] ? 1'b0 : (dp_valid && dp_owner == IW'(i)) ? HREADYOUTM : 1'b1;
            HRESPS[2*i +: 2] = (dp_valid && dp_owner == IW'(i)) ? HRESPM : 2'b00;
            if (dp_owner == IW'(i)) HWDATAM = HWDATAS[i*DW +: DW];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner <= '0;
            ptr <= '0;
            dp_valid <= 1'b0;
            dp_owner <= '0;
            last_c <= '0;
            hvalid <= '0;
            for (int i = 0; i < NUM_PORTS; i++) hold_c[i] <= '0;
        end else begin
            owner <= grant;
            if (msel) last_c <= m;
            if (arb_pt && any_req) ptr <= (winner == IW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
            if (HREADYOUTM) begin
                dp_valid <= msel & m.trans[1];
                dp_owner <= grant;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (issue && grant == IW'(i)) hvalid[i] <= 1'b0;
                else if (NUM_PORTS > 1 && live[i]) begin
                    hvalid[i] <= 1'b1;
                    hold_c[i] <= live_c[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_master_mux_n.sv
// tb_ahb_master_mux_n: directed stimulus with a transfer scoreboard for the N-port AHB master mux,
// one instance per arbitration mode sharing the same port-side drivers.
module tb_ahb_master_mux_n;
    logic clk, rst_n;
    logic [2:0]  hsels, hwrites, hlocks;
    logic [95:0] haddrs, hwdatas;
    logic [5:0]  htranss;
    logic [8:0]  hsizes, hbursts;
    logic [11:0] hprots;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;

    logic [2:0]  rdyo0, rdyo1, sizem0, sizem1, burstm0, burstm1, masterm0, masterm1;
    logic [5:0]  resps0, resps1;
    logic [95:0] rdatas0, rdatas1;
    logic        selm0, selm1, writem0, writem1, lockm0, lockm1, readym0, readym1;
    logic [31:0] addrm0, addrm1, wdatam0, wdatam1;
    logic [1:0]  transm0, transm1;
    logic [3:0]  protm0, protm1;

    typedef struct { logic [31:0] a; logic [2:0] m; } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int checks = 0, errors = 0;
    logic mon_sel = 1'b0;

    ahb_master_mux_n #(.ARB_MODE(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSELS(hsels), .HADDRS(haddrs), .HTRANSS(htranss),
        .HSIZES(hsizes), .HWRITES(hwrites), .HPROTS(hprots), .HBURSTS(hbursts),
        .HMASTLOCKS(hlocks), .HWDATAS(hwdatas), .HREADYS(rdyo0), .HREADYOUTS(rdyo0),
        .HRESPS(resps0), .HRDATAS(rdatas0), .HSELM(selm0), .HADDRM(addrm0), .HTRANSM(transm0),
        .HSIZEM(sizem0), .HWRITEM(writem0), .HPROTM(protm0), .HBURSTM(burstm0),
        .HMASTLOCKM(lockm0), .HWDATAM(wdatam0), .HREADYM(readym0), .HMASTERM(masterm0),
        .HREADYOUTM(rdy), .HRESPM(resp), .HRDATAM(rdata));

    ahb_master_mux_n #(.ARB_MODE(1)) dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HSELS(hsels), .HADDRS(haddrs), .HTRANSS(htranss),
        .HSIZES(hsizes), .HWRITES(hwrites), .HPROTS(hprots), .HBURSTS(hbursts),
        .HMASTLOCKS(hlocks), .HWDATAS(hwdatas), .HREADYS(rdyo1), .HREADYOUTS(rdyo1),
        .HRESPS(resps1), .HRDATAS(rdatas1), .HSELM(selm1), .HADDRM(addrm1), .HTRANSM(transm1),
        .HSIZEM(sizem1), .HWRITEM(writem1), .HPROTM(protm1), .HBURSTM(burstm1),
        .HMASTLOCKM(lockm1), .HWDATAM(wdatam1), .HREADYM(readym1), .HMASTERM(masterm1),
        .HREADYOUTM(rdy), .HRESPM(resp), .HRDATAM(rdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [2:0] m);
        exp_t e;
        e.a = a;
        e.m = m;
        q.push_back(e);
    endtask

    task automatic port(input int i, input logic [1:0] t, input logic [31:0] a,
                        input logic [2:0] b, input logic l);
        hsels[i] = (t != 2'b00);
        htranss[2*i +: 2] = t;
        haddrs[32*i +: 32] = a;
        hbursts[3*i +: 3] = b;
        hlocks[i] = l;
        hsizes[3*i +: 3] = 3'b010;
        hprots[4*i +: 4] = 4'b0011;
        hwrites[i] = 1'b0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) port(i, 2'b00, 32'h0, 3'b000, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        rdy = 1'b1;
        resp = 2'b00;
        @(negedge clk);
        chk("rst_trans", transm0, 2'b00);
        chk("rst_sel", selm0, 1'b0);
        chk("rst_lock", lockm0, 1'b0);
        chk("rst_master", masterm0, 3'd0);
        chk("rst_readyouts", rdyo0, 3'b111);
        chk("rst_resps", resps0, 6'd0);
        step();
        rst_n = 1'b1;
    endtask

    // scoreboard: every transfer accepted on the master port must match the next expected one
    always @(negedge clk) begin
        if (rst_n && (mon_sel ? (selm1 & transm1[1] & readym1) : (selm0 & transm0[1] & readym0))) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected got addr=%h master=%0d want none",
                         mon_sel ? addrm1 : addrm0, mon_sel ? masterm1 : masterm0);
            end else begin
                mon_e = q.pop_front();
                if ((mon_sel ? addrm1 : addrm0) !== mon_e.a || (mon_sel ? masterm1 : masterm0) !== mon_e.m) begin
                    errors++;
                    $display("FAIL xfer got addr=%h master=%0d want addr=%h master=%0d",
                             mon_sel ? addrm1 : addrm0, mon_sel ? masterm1 : masterm0, mon_e.a, mon_e.m);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rdata = '0;
        hwdatas = '0;
        idle_all();
        rdy = 1'b1;
        resp = 2'b00;
        // single port, zero latency pass-through
        do_reset();
        port(0, 2'b10, 32'h0000_1000, 3'b000, 1'b0);
        push(32'h0000_1000, 3'd0);
        @(negedge clk);
        chk("t1_addr", addrm0, 32'h0000_1000);
        chk("t1_trans", transm0, 2'b10);
        chk("t1_master", masterm0, 3'd0);
        step();
        idle_all();
        rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("t1_rdata", rdatas0[31:0], 32'hCAFE_0001);
        chk("t1_rdy21", rdyo0[2:1], 2'b11);
        chk("t1_rdy0", rdyo0[0], 1'b1);
        step();
        chk("t1_queue", q.size(), 0);
        // fixed priority collision, port 2 held and replayed
        do_reset();
        port(0, 2'b10, 32'h100, 3'b000, 1'b0);
        port(2, 2'b10, 32'h200, 3'b000, 1'b0);
        hwrites[2] = 1'b1;
        push(32'h100, 3'd0);
        push(32'h200, 3'd2);
        @(negedge clk);
        chk("t2_master0", masterm0, 3'd0);
        step();
        idle_all();
        @(negedge clk);
        chk("t2_rdy2_held", rdyo0[2], 1'b0);
        chk("t2_addr", addrm0, 32'h200);
        chk("t2_master2", masterm0, 3'd2);
        chk("t2_write", writem0, 1'b1);
        step();
        hwdatas[95:64] = 32'hD2D2_D2D2;
        @(negedge clk);
        chk("t2_rdy2_done", rdyo0[2], 1'b1);
        chk("t2_wdata", wdatam0, 32'hD2D2_D2D2);
        step();
        chk("t2_queue", q.size(), 0);
        // round-robin over three back-to-back requesters
        do_reset();
        mon_sel = 1'b1;
        for (int c = 0; c < 8; c++) push(32'h10 * ((c % 3) + 1), 3'(c % 3));
        for (int c = 0; c < 8; c++) begin
            if (c < 6) for (int i = 0; i < 3; i++) port(i, 2'b10, 32'h10 * (i + 1), 3'b000, 1'b0);
            else idle_all();
            @(negedge clk);
            chk("t3_rr_master", masterm1, 3'(c % 3));
            step();
        end
        chk("t3_queue", q.size(), 0);
        mon_sel = 1'b0;
        // INCR4 retention, then lock retention
        do_reset();
        port(1, 2'b10, 32'h40, 3'b011, 1'b0);
        push(32'h40, 3'd1);
        @(negedge clk);
        step();
        port(1, 2'b11, 32'h44, 3'b011, 1'b0);
        port(0, 2'b10, 32'h80, 3'b000, 1'b0);
        push(32'h44, 3'd1);
        @(negedge clk);
        chk("t4_burst_master", masterm0, 3'd1);
        step();
        port(1, 2'b11, 32'h48, 3'b011, 1'b0);
        port(0, 2'b00, 32'h0, 3'b000, 1'b0);
        push(32'h48, 3'd1);
        @(negedge clk);
        chk("t4_rdy0_held", rdyo0[0], 1'b0);
        step();
        port(1, 2'b11, 32'h4C, 3'b011, 1'b0);
        push(32'h4C, 3'd1);
        @(negedge clk);
        step();
        port(1, 2'b00, 32'h0, 3'b000, 1'b0);
        push(32'h80, 3'd0);
        @(negedge clk);
        chk("t4_after_burst", masterm0, 3'd0);
        step();
        port(1, 2'b10, 32'h60, 3'b000, 1'b1);
        push(32'h60, 3'd1);
        @(negedge clk);
        step();
        port(1, 2'b10, 32'h64, 3'b000, 1'b1);
        port(0, 2'b10, 32'h90, 3'b000, 1'b0);
        push(32'h64, 3'd1);
        @(negedge clk);
        chk("t4_lockm", lockm0, 1'b1);
        chk("t4_lock_master", masterm0, 3'd1);
        step();
        idle_all();
        push(32'h90, 3'd0);
        @(negedge clk);
        chk("t4_after_lock", masterm0, 3'd0);
        step();
        chk("t4_queue", q.size(), 0);
        // two-cycle ERROR to owner while port 1 is held
        do_reset();
        port(0, 2'b10, 32'h100, 3'b000, 1'b0);
        port(1, 2'b10, 32'h204, 3'b000, 1'b0);
        push(32'h100, 3'd0);
        @(negedge clk);
        step();
        idle_all();
        rdy = 1'b0;
        resp = 2'b01;
        @(negedge clk);
        chk("t5_resp0_c1", resps0[1:0], 2'b01);
        chk("t5_rdy0_c1", rdyo0[0], 1'b0);
        chk("t5_resp1_c1", resps0[3:2], 2'b00);
        chk("t5_rdy1_c1", rdyo0[1], 1'b0);
        step();
        rdy = 1'b1;
        push(32'h204, 3'd1);
        @(negedge clk);
        chk("t5_resp0_c2", resps0[1:0], 2'b01);
        chk("t5_rdy0_c2", rdyo0[0], 1'b1);
        chk("t5_resp1_c2", resps0[3:2], 2'b00);
        chk("t5_replay_addr", addrm0, 32'h204);
        step();
        resp = 2'b00;
        @(negedge clk);
        chk("t5_rdy1_done", rdyo0[1], 1'b1);
        chk("t5_resp1_done", resps0[3:2], 2'b00);
        step();
        chk("t5_queue", q.size(), 0);
        // asynchronous reset mid-burst during a wait state
        do_reset();
        port(1, 2'b10, 32'h40, 3'b011, 1'b0);
        push(32'h40, 3'd1);
        @(negedge clk);
        step();
        port(1, 2'b11, 32'h44, 3'b011, 1'b0);
        rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_trans", transm0, 2'b00);
        chk("t6_sel", selm0, 1'b0);
        chk("t6_master", masterm0, 3'd0);
        chk("t6_readyouts", rdyo0, 3'b111);
        chk("t6_resps", resps0, 6'd0);
        chk("t6_trans_rr", transm1, 2'b00);
        step();
        rst_n = 1'b1;
        rdy = 1'b1;
        port(1, 2'b10, 32'h300, 3'b000, 1'b0);
        push(32'h300, 3'd1);
        @(negedge clk);
        chk("t6_post_addr", addrm0, 32'h300);
        chk("t6_post_master", masterm0, 3'd1);
        chk("t6_post_trans", transm0, 2'b10);
        step();
        idle_all();
        step();
        chk("t6_queue", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
